// File: rtl/l2_cache_read_stage_if.sv
// l2_cache_read_stage_if: directory-side request, SRAM write port and response-side bus of the L2 read stage.
interface l2_cache_read_stage_if #(
  parameter int NUM_WAYS      = 4,
  parameter int NUM_SETS      = 256,
  parameter int LINE_BITS     = 512,
  parameter int ADDR_WIDTH    = 26,
  parameter int TOTAL_STRANDS = 4,
  parameter int SIDEBAND_W    = 64
);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int IDX_W = WAY_W + SET_W;
  localparam int ID_W  = $clog2(TOTAL_STRANDS);
  localparam int REQ_W = 3 + ID_W + ADDR_WIDTH + 2 + 2 * WAY_W + SIDEBAND_W;
  logic                  dir_valid;
  logic                  dir_ready;
  logic [2:0]            dir_op;
  logic [ID_W-1:0]       dir_id;
  logic [ADDR_WIDTH-1:0] dir_address;
  logic                  dir_is_fill;
  logic                  dir_cache_hit;
  logic [WAY_W-1:0]      dir_hit_way;
  logic [WAY_W-1:0]      dir_fill_way;
  logic [NUM_WAYS-1:0]   dir_dirty;
  logic [SIDEBAND_W-1:0] dir_sideband;
  logic                  wr_enable;
  logic [IDX_W-1:0]      wr_index;
  logic [LINE_BITS-1:0]  wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [REQ_W-1:0]      rd_req;
  logic [IDX_W-1:0]      rd_cache_index;
  logic [LINE_BITS-1:0]  rd_cache_data;
  logic                  rd_line_dirty;
  logic                  rd_store_sync_success;
  modport slave (
    input  dir_valid, dir_op, dir_id, dir_address, dir_is_fill, dir_cache_hit,
           dir_hit_way, dir_fill_way, dir_dirty, dir_sideband,
           wr_enable, wr_index, wr_data, rd_ready,
    output dir_ready, rd_valid, rd_req, rd_cache_index, rd_cache_data,
           rd_line_dirty, rd_store_sync_success
  );
  modport master (
    output dir_valid, dir_op, dir_id, dir_address, dir_is_fill, dir_cache_hit,
           dir_hit_way, dir_fill_way, dir_dirty, dir_sideband,
           wr_enable, wr_index, wr_data, rd_ready,
    input  dir_ready, rd_valid, rd_req, rd_cache_index, rd_cache_data,
           rd_line_dirty, rd_store_sync_success
  );
endinterface

// File: rtl/l2_cache_read_stage.sv
// l2_cache_read_stage: L2 data-read stage with valid/ready hold, stall-time write coherence and sync reservations.
// Define L2_RD_BYPASS_EN to forward a same-cycle SRAM write to the read; otherwise the SRAM is read-first.
module l2_cache_read_stage #(
  parameter int NUM_WAYS      = 4,
  parameter int NUM_SETS      = 256,
  parameter int LINE_BITS     = 512,
  parameter int ADDR_WIDTH    = 26,
  parameter int TOTAL_STRANDS = 4,
  parameter int SIDEBAND_W    = 64
) (
  input logic                  clk,
  input logic                  reset_n,
  l2_cache_read_stage_if.slave bus
);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int IDX_W = WAY_W + SET_W;
  localparam int ID_W  = $clog2(TOTAL_STRANDS);
  localparam int REQ_W = 3 + ID_W + ADDR_WIDTH + 2 + 2 * WAY_W + SIDEBAND_W;
  localparam logic [2:0] OP_STORE      = 3'd1;
  localparam logic [2:0] OP_FLUSH      = 3'd2;
  localparam logic [2:0] OP_INVALIDATE = 3'd3;
  localparam logic [2:0] OP_LOAD_SYNC  = 3'd4;
  localparam logic [2:0] OP_STORE_SYNC = 3'd5;

  logic [LINE_BITS-1:0]  mem_q [NUM_WAYS*NUM_SETS];
  logic [LINE_BITS-1:0]  sram_q, sram_d, hold_q, hold_d;
  logic [ADDR_WIDTH-1:0] res_addr_q [TOTAL_STRANDS];
  logic [ADDR_WIDTH-1:0] res_addr_d [TOTAL_STRANDS];
  logic [TOTAL_STRANDS-1:0] res_vld_q, res_vld_d;
  logic                  valid_q, valid_d, fresh_q, dirty_q, dirty_d, succ_q, succ_d;
  logic [REQ_W-1:0]      req_q, req_d;
  logic [IDX_W-1:0]      idx_q, idx_d, rd_idx;
  logic                  ready, accept, upd, succ, rd_fwd;

  assign ready  = !valid_q || bus.rd_ready;
  assign accept = bus.dir_valid && ready;
  assign upd    = bus.dir_cache_hit || bus.dir_is_fill;
  assign rd_idx = {bus.dir_is_fill ? bus.dir_fill_way : bus.dir_hit_way, bus.dir_address[SET_W-1:0]};
  assign succ   = bus.dir_op == OP_STORE_SYNC && res_vld_q[bus.dir_id] &&
                  res_addr_q[bus.dir_id] == bus.dir_address && upd;

`ifdef L2_RD_BYPASS_EN
  assign rd_fwd = bus.wr_enable && bus.wr_index == rd_idx;
`else
  assign rd_fwd = 1'b0;
  a_no_rd_wr_collision: assert property (@(posedge clk) disable iff (!reset_n)
    !(accept && bus.wr_enable && bus.wr_index == rd_idx));
`endif

  a_no_fill_hit: assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.dir_valid && bus.dir_is_fill && bus.dir_cache_hit));

  always_comb begin
    valid_d = accept ? 1'b1 : bus.rd_ready ? 1'b0 : valid_q;
    req_d   = accept ? {bus.dir_op, bus.dir_id, bus.dir_address, bus.dir_is_fill, bus.dir_cache_hit,
                        bus.dir_hit_way, bus.dir_fill_way, bus.dir_sideband} : req_q;
    idx_d   = accept ? rd_idx : idx_q;
    dirty_d = accept ? bus.dir_dirty[bus.dir_op == OP_FLUSH ? bus.dir_hit_way : bus.dir_fill_way] : dirty_q;
    succ_d  = accept ? succ : succ_q;
    sram_d  = rd_fwd ? bus.wr_data : mem_q[rd_idx];
    // a write to the held line must win over the just-read copy
    hold_d  = (valid_q && bus.wr_enable && bus.wr_index == idx_q) ? bus.wr_data :
              fresh_q ? sram_q : hold_q;
  end

  always_comb begin
    res_addr_d = res_addr_q;
    res_vld_d  = res_vld_q;
    if (accept && upd) begin
      if (bus.dir_op == OP_LOAD_SYNC) begin
        res_addr_d[bus.dir_id] = bus.dir_address;
        res_vld_d[bus.dir_id]  = 1'b1;
      end else if (bus.dir_op == OP_STORE || bus.dir_op == OP_INVALIDATE || succ) begin
        for (int i = 0; i < TOTAL_STRANDS; i++)
          if (res_addr_q[i] == bus.dir_address) res_vld_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      fresh_q   <= 1'b0;
      req_q     <= '0;
      idx_q     <= '0;
      dirty_q   <= 1'b0;
      succ_q    <= 1'b0;
      hold_q    <= '0;
      res_vld_q <= '0;
      for (int i = 0; i < TOTAL_STRANDS; i++) res_addr_q[i] <= '0;
    end else begin
      valid_q    <= valid_d;
      fresh_q    <= accept;
      req_q      <= req_d;
      idx_q      <= idx_d;
      dirty_q    <= dirty_d;
      succ_q     <= succ_d;
      hold_q     <= hold_d;
      res_vld_q  <= res_vld_d;
      res_addr_q <= res_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.wr_enable) mem_q[bus.wr_index] <= bus.wr_data;
    if (accept) sram_q <= sram_d;
  end

  assign bus.dir_ready             = ready;
  assign bus.rd_valid              = valid_q;
  assign bus.rd_req                = req_q;
  assign bus.rd_cache_index        = idx_q;
  assign bus.rd_cache_data         = fresh_q ? sram_q : hold_q;
  assign bus.rd_line_dirty         = dirty_q;
  assign bus.rd_store_sync_success = succ_q;
endmodule
